// File: rtl/trans_addr_mp.sv
// Multi-port VA->PA translator (DA, DMW0/DMW1, fully-associative TLB) with one registered response per port.
// Latency 1 cycle; a stalled response (resp_valid & !resp_ready) holds its fields and drops req_ready.
module trans_addr_mp #(
  parameter int          NUM_PORTS = 2,
  parameter int          TLBNUM    = 16,
  parameter logic [15:0] UC_HI     = 16'hbfaf
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [32*NUM_PORTS-1:0]   req_vaddr,
  input  logic [NUM_PORTS-1:0]      req_fetch,
  input  logic [NUM_PORTS-1:0]      req_store,
  output logic [NUM_PORTS-1:0]      resp_valid,
  input  logic [NUM_PORTS-1:0]      resp_ready,
  output logic [32*NUM_PORTS-1:0]   resp_paddr,
  output logic [NUM_PORTS-1:0]      resp_uncache,
  output logic [3*NUM_PORTS-1:0]    resp_ecode,
  input  logic                      csr_da,
  input  logic                      csr_pg,
  input  logic [1:0]                csr_plv,
  input  logic [1:0]                csr_datf,
  input  logic [1:0]                csr_datm,
  input  logic [9:0]                csr_asid,
  input  logic [31:0]               csr_dmw0,
  input  logic [31:0]               csr_dmw1,
  input  logic                      tlb_we,
  input  logic [$clog2(TLBNUM)-1:0] tlb_windex,
  input  logic [88:0]               tlb_wentry,
  input  logic                      tlb_inv_all
);

  localparam int IW = $clog2(TLBNUM);

  localparam logic [2:0] EC_NONE = 3'd0;
  localparam logic [2:0] EC_TLBR = 3'd1;
  localparam logic [2:0] EC_PIF  = 3'd2;
  localparam logic [2:0] EC_PIL  = 3'd3;
  localparam logic [2:0] EC_PIS  = 3'd4;
  localparam logic [2:0] EC_PPI  = 3'd5;
  localparam logic [2:0] EC_PME  = 3'd6;

  typedef struct packed {
    logic        vld;
    logic        dirty;
    logic [1:0]  mat;
    logic [1:0]  plv;
    logic [19:0] ppn;
  } tlb_page_t;

  // Entry payload without the e bit; e lives in its own resettable vector.
  typedef struct packed {
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_body_t;

  logic [TLBNUM-1:0] tlb_e;
  tlb_body_t         tlb_mem [TLBNUM];

  // Invalidate-all is applied first so a same-cycle write survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlb_e <= '0;
    end else begin
      if (tlb_inv_all) tlb_e <= '0;
      if (tlb_we)      tlb_e[tlb_windex] <= tlb_wentry[88];
    end
  end

  always_ff @(posedge clk) begin
    if (tlb_we) tlb_mem[tlb_windex] <= tlb_wentry[87:0];
  end

  logic da_mode;
  logic dmw0_plv_ok;
  logic dmw1_plv_ok;
  logic unused_dmw;

  assign da_mode     = csr_da & ~csr_pg;
  assign dmw0_plv_ok = (csr_dmw0[0] & (csr_plv == 2'd0)) | (csr_dmw0[3] & (csr_plv == 2'd3));
  assign dmw1_plv_ok = (csr_dmw1[0] & (csr_plv == 2'd0)) | (csr_dmw1[3] & (csr_plv == 2'd3));
  assign unused_dmw  = ^{csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                         csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [31:0]       va;
    logic              fetch;
    logic              store;
    logic              dmw0_hit;
    logic              dmw1_hit;
    logic [TLBNUM-1:0] match;
    logic              tlb_hit;
    logic [IW-1:0]     hit_idx;
    logic              hit_big;
    logic              odd;
    tlb_page_t         pg;
    logic [31:0]       paddr_n;
    logic [1:0]        mat_n;
    logic [2:0]        ecode_n;
    logic              uc_n;
    logic              accept;
    logic              vld_q;
    logic [31:0]       paddr_q;
    logic              uc_q;
    logic [2:0]        ecode_q;

    assign va       = req_vaddr[32*p +: 32];
    assign fetch    = req_fetch[p];
    assign store    = req_store[p] & ~req_fetch[p];
    assign dmw0_hit = dmw0_plv_ok & (va[31:29] == csr_dmw0[31:29]);
    assign dmw1_hit = dmw1_plv_ok & (va[31:29] == csr_dmw1[31:29]);

    always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
        match[i] = tlb_e[i] & (tlb_mem[i].g | (tlb_mem[i].asid == csr_asid)) &
                   (((tlb_mem[i].ps == 6'd12) & (tlb_mem[i].vppn == va[31:13])) |
                    ((tlb_mem[i].ps == 6'd21) & (tlb_mem[i].vppn[18:8] == va[31:21])));
      end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
      tlb_hit = 1'b0;
      hit_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (match[i]) begin
          tlb_hit = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end

    assign hit_big = (tlb_mem[hit_idx].ps == 6'd21);
    assign odd     = hit_big ? va[21] : va[12];
    assign pg      = odd ? tlb_mem[hit_idx].p1 : tlb_mem[hit_idx].p0;

    always_comb begin
      paddr_n = va;
      mat_n   = 2'd0;
      ecode_n = EC_NONE;
      if (da_mode) begin
        mat_n = fetch ? csr_datf : csr_datm;
      end else if (dmw0_hit) begin
        paddr_n = {csr_dmw0[27:25], va[28:0]};
        mat_n   = csr_dmw0[5:4];
      end else if (dmw1_hit) begin
        paddr_n = {csr_dmw1[27:25], va[28:0]};
        mat_n   = csr_dmw1[5:4];
      end else if (!tlb_hit) begin
        ecode_n = EC_TLBR;
      end else if (!pg.vld) begin
        ecode_n = fetch ? EC_PIF : (store ? EC_PIS : EC_PIL);
      end else if (csr_plv > pg.plv) begin
        ecode_n = EC_PPI;
      end else if (store & ~pg.dirty) begin
        ecode_n = EC_PME;
      end else begin
        mat_n   = pg.mat;
        paddr_n = hit_big ? {pg.ppn[19:9], va[20:0]} : {pg.ppn, va[11:0]};
      end
    end

    assign uc_n = (ecode_n == EC_NONE) &
                  ((mat_n == 2'd0) | ((va[31:16] == UC_HI) & ~fetch));

    assign req_ready[p] = ~vld_q | resp_ready[p];
    assign accept       = req_valid[p] & req_ready[p];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q   <= 1'b0;
        paddr_q <= '0;
        uc_q    <= 1'b0;
        ecode_q <= EC_NONE;
      end else if (accept) begin
        vld_q   <= 1'b1;
        paddr_q <= paddr_n;
        uc_q    <= uc_n;
        ecode_q <= ecode_n;
      end else if (resp_ready[p]) begin
        vld_q   <= 1'b0;
      end
    end

    assign resp_valid[p]          = vld_q;
    assign resp_paddr[32*p +: 32] = paddr_q;
    assign resp_uncache[p]        = uc_q;
    assign resp_ecode[3*p +: 3]   = ecode_q;
  end

endmodule

// File: tb/tb_trans_addr_mp.sv
// Scoreboard bench for trans_addr_mp: per-port expected/observed queues compared inside each scenario task.
module tb_trans_addr_mp;
  localparam int NP = 2;
  localparam int TN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_valid, req_ready, req_fetch, req_store;
  logic [NP-1:0] resp_valid, resp_ready, resp_uncache;
  logic [32*NP-1:0] req_vaddr, resp_paddr;
  logic [3*NP-1:0]  resp_ecode;
  logic        csr_da, csr_pg;
  logic [1:0]  csr_plv, csr_datf, csr_datm;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0, csr_dmw1;
  logic        tlb_we, tlb_inv_all;
  logic [$clog2(TN)-1:0] tlb_windex;
  logic [88:0] tlb_wentry;

  localparam logic [88:0] ENT3 = {1'b1, 10'h000, 1'b1, 6'd12, 19'h00100,
                                  1'b0, 1'b0, 2'd0, 2'd0, 20'h00000,
                                  1'b1, 1'b0, 2'd1, 2'd3, 20'h12345};
  localparam logic [88:0] ENT5 = {1'b1, 10'h055, 1'b0, 6'd21, 19'h02500,
                                  1'b0, 1'b0, 2'd0, 2'd0, 20'h00000,
                                  1'b1, 1'b1, 2'd0, 2'd0, 20'habc00};

  typedef struct packed {
    logic [31:0] pa;
    logic        uc;
    logic [2:0]  ec;
  } exp_t;

  exp_t sb0[$], sb1[$], obs0[$], obs1[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trans_addr_mp #(.NUM_PORTS(NP), .TLBNUM(TN), .UC_HI(16'hbfaf)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_fetch(req_fetch), .req_store(req_store),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_uncache(resp_uncache), .resp_ecode(resp_ecode),
    .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv),
    .csr_datf(csr_datf), .csr_datm(csr_datm), .csr_asid(csr_asid),
    .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .tlb_we(tlb_we), .tlb_windex(tlb_windex), .tlb_wentry(tlb_wentry),
    .tlb_inv_all(tlb_inv_all)
  );

  // Monitor: record every response that completes its handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (resp_valid[0] && resp_ready[0]) obs0.push_back({resp_paddr[31:0], resp_uncache[0], resp_ecode[2:0]});
      if (resp_valid[1] && resp_ready[1]) obs1.push_back({resp_paddr[63:32], resp_uncache[1], resp_ecode[5:3]});
    end
  end

  task automatic send(input int p, input logic [31:0] va, input logic f, input logic s,
                      input logic [31:0] pa, input logic uc, input logic [2:0] ec);
    req_valid[p] = 1'b1;
    req_vaddr[32*p +: 32] = va;
    req_fetch[p] = f;
    req_store[p] = s;
    if (p == 0) sb0.push_back({pa, uc, ec});
    else        sb1.push_back({pa, uc, ec});
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_obs(input int p, input int n);
    int cyc = 0;
    while (((p == 0) ? obs0.size() : obs1.size()) < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic tlb_write(input int idx, input logic [88:0] ent);
    tlb_we = 1'b1;
    tlb_windex = idx[$clog2(TN)-1:0];
    tlb_wentry = ent;
    @(posedge clk); #1;
    tlb_we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_uncache, resp_ecode, resp_paddr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: vld=%b uc=%b ec=%h pa=%h, want all zero",
               resp_valid, resp_uncache, resp_ecode, resp_paddr);
    end
    total++;
    if (req_ready !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready: got %b want 11", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_da;
    exp_t w, g;
    csr_da = 1'b1; csr_pg = 1'b0; csr_datm = 2'd0; csr_datf = 2'd1;
    send(0, 32'h1c000100, 1'b0, 1'b0, 32'h1c000100, 1'b1, 3'd0);
    send(0, 32'hbfaf0040, 1'b1, 1'b0, 32'hbfaf0040, 1'b0, 3'd0);
    csr_datm = 2'd1;
    send(0, 32'hbfaf0040, 1'b0, 1'b0, 32'hbfaf0040, 1'b1, 3'd0);
    send(0, 32'h1c000200, 1'b0, 1'b1, 32'h1c000200, 1'b0, 3'd0);
    wait_obs(0, sb0.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL da: no response, want pa=%h uc=%b ec=%0d", w.pa, w.uc, w.ec);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL da: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
    total++;
    if (obs0.size() != 0) begin
      bad++; $display("FAIL da_extra: %0d unexpected responses, want 0", obs0.size());
      obs0.delete();
    end
  endtask

  task automatic test_dmw;
    exp_t w, g;
    csr_da = 1'b0; csr_pg = 1'b1;
    csr_dmw0 = 32'h80000011; csr_dmw1 = 32'h82000009;
    csr_plv = 2'd0;
    send(0, 32'h80002040, 1'b0, 1'b0, 32'h00002040, 1'b0, 3'd0);
    csr_plv = 2'd3;
    send(0, 32'h80002040, 1'b0, 1'b0, 32'h20002040, 1'b1, 3'd0);
    csr_dmw1 = 32'h0;
    send(0, 32'h80002040, 1'b0, 1'b0, 32'h80002040, 1'b0, 3'd1);
    wait_obs(0, sb0.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL dmw: no response, want pa=%h uc=%b ec=%0d", w.pa, w.uc, w.ec);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL dmw: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
  endtask

  task automatic test_tlb;
    exp_t w, g;
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd3; csr_asid = 10'h055;
    tlb_write(3, ENT3);
    tlb_write(5, ENT5);
    send(0, 32'h00201abc, 1'b0, 1'b1, 32'h00201abc, 1'b0, 3'd6);
    send(0, 32'h00201abc, 1'b0, 1'b0, 32'h12345abc, 1'b0, 3'd0);
    send(0, 32'h00200010, 1'b1, 1'b0, 32'h00200010, 1'b0, 3'd2);
    send(0, 32'h00200010, 1'b0, 1'b1, 32'h00200010, 1'b0, 3'd4);
    send(0, 32'h04abcdef, 1'b0, 1'b0, 32'h04abcdef, 1'b0, 3'd5);
    csr_plv = 2'd0;
    send(0, 32'h04abcdef, 1'b0, 1'b0, 32'habcbcdef, 1'b1, 3'd0);
    csr_asid = 10'h056;
    send(0, 32'h04abcdef, 1'b0, 1'b0, 32'h04abcdef, 1'b0, 3'd1);
    csr_asid = 10'h055;
    wait_obs(0, sb0.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL tlb: no response, want pa=%h uc=%b ec=%0d", w.pa, w.uc, w.ec);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL tlb: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
  endtask

  task automatic test_inv;
    exp_t w, g;
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_asid = 10'h055;
    // Lookup accepted on the invalidate edge still sees the old entry.
    tlb_inv_all = 1'b1;
    send(0, 32'h00201abc, 1'b0, 1'b0, 32'h12345abc, 1'b0, 3'd0);
    tlb_inv_all = 1'b0;
    send(0, 32'h00201abc, 1'b0, 1'b0, 32'h00201abc, 1'b0, 3'd1);
    tlb_write(5, ENT5);
    tlb_inv_all = 1'b1;
    tlb_write(3, ENT3);
    tlb_inv_all = 1'b0;
    send(0, 32'h00201abc, 1'b0, 1'b0, 32'h12345abc, 1'b0, 3'd0);
    send(0, 32'h04abcdef, 1'b0, 1'b0, 32'h04abcdef, 1'b0, 3'd1);
    wait_obs(0, sb0.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL inv: no response, want pa=%h uc=%b ec=%0d", w.pa, w.uc, w.ec);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL inv: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t w, g;
    logic [31:0] va;
    csr_da = 1'b1; csr_pg = 1'b0; csr_datm = 2'd1;
    req_fetch = '0; req_store = '0;
    for (int i = 0; i < 6; i++) begin
      va = 32'h00010000 + 32'(i * 16);
      req_valid[0] = 1'b1;
      req_vaddr[31:0] = va;
      sb0.push_back({va, 1'b0, 3'd0});
      if (i == 0) begin
        resp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_vaddr[63:32] = 32'h00020000;
        sb1.push_back({32'h00020000, 1'b0, 3'd0});
      end
      if (i == 1) begin
        req_vaddr[63:32] = 32'h00030000;
        sb1.push_back({32'h00030000, 1'b0, 3'd0});
      end
      if (i == 4) resp_ready[1] = 1'b1;
      if (i == 5) req_valid[1] = 1'b0;
      if (i >= 1 && i <= 3) begin
        @(negedge clk);
        total++;
        if (resp_valid[1] !== 1'b1 || resp_paddr[63:32] !== 32'h00020000 || resp_uncache[1] !== 1'b0 ||
            resp_ecode[5:3] !== 3'd0 || req_ready[1] !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold cyc%0d: vld=%b pa=%h uc=%b ec=%0d rdy=%b want vld=1 pa=00020000 uc=0 ec=0 rdy=0",
                   i, resp_valid[1], resp_paddr[63:32], resp_uncache[1], resp_ecode[5:3], req_ready[1]);
        end
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    wait_obs(0, sb0.size());
    wait_obs(1, sb1.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL b2b_p0: no response, want pa=%h", w.pa);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL b2b_p0: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
    while (sb1.size() > 0) begin
      w = sb1.pop_front();
      total++;
      if (obs1.size() == 0) begin
        bad++; $display("FAIL b2b_p1: no response, want pa=%h", w.pa);
      end else begin
        g = obs1.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL b2b_p1: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
    total++;
    if (obs0.size() + obs1.size() != 0) begin
      bad++; $display("FAIL b2b_extra: %0d unexpected responses, want 0", obs0.size() + obs1.size());
      obs0.delete(); obs1.delete();
    end
  endtask

  task automatic test_async_reset;
    exp_t w, g;
    csr_da = 1'b1; csr_pg = 1'b0; csr_datm = 2'd1;
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_vaddr[31:0] = 32'h00004000; req_fetch[0] = 1'b0; req_store[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2;
    total++;
    if (resp_valid[0] !== 1'b1 || resp_paddr[31:0] !== 32'h00004000) begin
      bad++; $display("FAIL pre_reset_hold: vld=%b pa=%h want vld=1 pa=00004000", resp_valid[0], resp_paddr[31:0]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (resp_valid !== 2'b00 || resp_paddr !== '0 || resp_uncache !== 2'b00 || resp_ecode !== '0) begin
      bad++; $display("FAIL async_reset: vld=%b pa=%h uc=%b ec=%h want all zero", resp_valid, resp_paddr, resp_uncache, resp_ecode);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    resp_ready[0] = 1'b1;
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd3;
    csr_dmw0 = 32'h80000011; csr_dmw1 = 32'h0;
    send(0, 32'h00201abc, 1'b0, 1'b0, 32'h00201abc, 1'b0, 3'd1);
    wait_obs(0, sb0.size());
    while (sb0.size() > 0) begin
      w = sb0.pop_front();
      total++;
      if (obs0.size() == 0) begin
        bad++; $display("FAIL post_reset_tlb: no response, want ec=%0d", w.ec);
      end else begin
        g = obs0.pop_front();
        if (g !== w) begin
          bad++; $display("FAIL post_reset_tlb: got pa=%h uc=%b ec=%0d want pa=%h uc=%b ec=%0d", g.pa, g.uc, g.ec, w.pa, w.uc, w.ec);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_vaddr = '0; req_fetch = '0; req_store = '0;
    resp_ready = 2'b11;
    csr_da = 1'b1; csr_pg = 1'b0; csr_plv = 2'd0;
    csr_datf = 2'd1; csr_datm = 2'd0; csr_asid = 10'h0;
    csr_dmw0 = 32'h0; csr_dmw1 = 32'h0;
    tlb_we = 1'b0; tlb_windex = '0; tlb_wentry = '0; tlb_inv_all = 1'b0;
    test_reset();
    test_da();
    test_dmw();
    test_tlb();
    test_inv();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
